spi_frame_loader: RTL and testbench
===================================

SPI_FRAME_LOADER -- requirements
Module: spi_frame_loader

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clock and reset; all other ports are synchronous to clock.
REQ-002 Parameter NUM_PIXELS, default 2048, is the pixel count per bank (power of two); ADDR_W = log2(NUM_PIXELS), 11 by default.
REQ-003 Port clock, input, 1: system clock, at least 2x the SPI clock.
REQ-004 Port reset, input, 1: asynchronous active-high reset.
REQ-005 Port rx_data, input, 8: received SPI byte, valid when rx_valid=1.
REQ-006 Port rx_valid, input, 1: one-cycle strobe, byte complete.
REQ-007 Port rx_first, input, 1: one-cycle strobe, start of a new SPI transaction.
REQ-008 Port frame_done, input, 1: one-cycle strobe from the scan stage at the end of each displayed frame.
REQ-009 Port wr_en, output, 1: pixel RAM write strobe.
REQ-010 Port wr_addr, output, ADDR_W+1: {bank, pixel index}.
REQ-011 Port wr_data, output, 16: RGB555 pixel (bit 15 passed through as sent).
REQ-012 Port front_bank, output, 1: bank the scan stage reads.
REQ-013 Port swap_pending, output, 1: swap requested, not yet taken.
REQ-014 Port overflow, output, 1: sticky flag, data arrived past the last pixel.

Function
REQ-015 FSM states SHALL be IDLE, CMD, ADDR_HI, ADDR_LO, PIX_HI, PIX_LO and DISCARD.
REQ-016 rx_first SHALL force state CMD from any state and clear overflow.
REQ-017 If rx_first and rx_valid occur in the same cycle, that byte SHALL be decoded as the command byte.
REQ-018 rx_valid in IDLE SHALL be ignored.
REQ-019 In CMD, rx_data 0x01 (WRITE) SHALL go to ADDR_HI; 0x02 (SWAP) SHALL set swap_pending and go to DISCARD; any other value SHALL go to DISCARD.
REQ-020 ADDR_HI and ADDR_LO SHALL capture a big-endian 16-bit start index; if the index >= NUM_PIXELS, the FSM SHALL go to DISCARD and set overflow, otherwise to PIX_HI.
REQ-021 PIX_HI SHALL latch the high byte and go to PIX_LO.
REQ-022 PIX_LO SHALL register wr_en=1, wr_data={hi,lo} and wr_addr={~front_bank, index} on the cycle after the rx_valid of the low byte (latency 1), then increment the index.
REQ-023 A write to index NUM_PIXELS-1 SHALL be followed by DISCARD; any further rx_valid in DISCARD SHALL set overflow. The index SHALL NOT wrap.
REQ-024 wr_en SHALL be a single-cycle pulse per pixel and 0 otherwise; wr_addr and wr_data SHALL hold their values when wr_en=0.
REQ-025 Writes SHALL always target the back bank (~front_bank), never the displayed bank.
REQ-026 On frame_done with swap_pending=1, front_bank SHALL toggle and swap_pending SHALL clear in the same edge.
REQ-027 A SWAP command decoded in the same cycle as frame_done SHALL leave swap_pending=1 and swap at the next frame_done; a SWAP while pending SHALL NOT cause a second toggle.
REQ-028 A write whose wr_en edge coincides with a swap SHALL use the pre-swap back bank; later pixels SHALL use the new back bank.
REQ-029 An odd trailing byte (PIX_HI latched, no low byte before rx_first) SHALL be discarded without a write.

Reset
REQ-030 Reset SHALL force state IDLE and set wr_en, wr_addr, wr_data, front_bank, swap_pending, overflow, the index and the high-byte latch all to 0.
REQ-031 Reset asserted mid-transaction SHALL abort without a write; after release, bytes SHALL be ignored until rx_first.

Structure
REQ-032 Package spi_frame_pkg SHALL hold the command codes CMD_WRITE=0x01 and CMD_SWAP=0x02, the FSM state enum and the NUM_PIXELS default.
REQ-033 Sub-module frame_bank_ctl SHALL own front_bank and swap_pending (inputs swap_req, frame_done); the parser FSM stays in spi_frame_loader.

Verification
REQ-034 rx_first, then bytes 01 00 00 7C 00 03 E0 -> two wr_en pulses: addr {1,0}=0x800 data 0x7C00, then 0x801 data 0x03E0; front_bank=0.
REQ-035 rx_first, 02, then frame_done -> swap_pending=1 until frame_done, then front_bank=1 and swap_pending=0; the next WRITE at index 0 gives wr_addr 0x000.
REQ-036 WRITE start 0x07FF, pixels AAAA, BBBB -> one write at 0xFFF data 0xAAAA, no second write, overflow=1; the next rx_first clears overflow.
REQ-037 SWAP byte rx_valid in the same cycle as frame_done -> no toggle that frame; toggle on the next frame_done; two SWAPs before it -> exactly one toggle.
REQ-038 Reset after 01 00 05 12 -> no wr_en, all outputs 0; bytes 34 56 after release with no rx_first -> no write.

Source files
------------

// File: rtl/spi_frame_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_frame_pkg
//  Brief    : Shared command codes, parser state encoding and default frame
//             size for the SPI frame loader.
//  Revision : 1.0 - initial release
// ============================================================================
package spi_frame_pkg;

    // Command byte values recognised as the first byte of a transaction
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_SWAP  = 8'h02;

    // Pixels per bank; must be a power of two
    localparam int NUM_PIXELS_DEFAULT = 2048;

    // Byte-stream parser states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        ADDR_HI = 3'd2,
        ADDR_LO = 3'd3,
        PIX_HI  = 3'd4,
        PIX_LO  = 3'd5,
        DISCARD = 3'd6
    } state_t;

endpackage : spi_frame_pkg
`default_nettype wire

// File: rtl/frame_bank_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : frame_bank_ctl
//  Brief    : Double-buffer bank selector. A swap request is held pending and
//             taken on the next end-of-frame strobe so the displayed bank only
//             changes between frames.
//  Revision : 1.0 - initial release
// ============================================================================
module frame_bank_ctl (
    input  logic clock,
    input  logic reset,
    input  logic swap_req,
    input  logic frame_done,
    output logic front_bank,
    output logic swap_pending
);

    logic front_bank_q;
    logic front_bank_d;
    logic swap_pending_q;
    logic swap_pending_d;

    // Next-state: take a pending swap at frame end; a request arriving on the
    // same edge re-arms pending so it is served at the following frame end.
    always_comb begin
        front_bank_d   = front_bank_q;
        swap_pending_d = swap_pending_q;
        if (frame_done && swap_pending_q) begin
            front_bank_d   = ~front_bank_q;
            swap_pending_d = 1'b0;
        end
        if (swap_req) begin
            swap_pending_d = 1'b1;
        end
    end

    // Bank state registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            front_bank_q   <= 1'b0;
            swap_pending_q <= 1'b0;
        end else begin
            front_bank_q   <= front_bank_d;
            swap_pending_q <= swap_pending_d;
        end
    end

    assign front_bank   = front_bank_q;
    assign swap_pending = swap_pending_q;

endmodule : frame_bank_ctl
`default_nettype wire

// File: rtl/spi_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module   : spi_frame_loader
//  Brief    : Parses SPI byte transactions (WRITE / SWAP) and writes RGB555
//             pixels into the back bank of a double-buffered pixel RAM.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_frame_loader
    import spi_frame_pkg::*;
#(
    parameter int NUM_PIXELS = NUM_PIXELS_DEFAULT,
    parameter int ADDR_W     = $clog2(NUM_PIXELS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              rx_first,
    input  logic              frame_done,
    output logic              wr_en,
    output logic [ADDR_W:0]   wr_addr,
    output logic [15:0]       wr_data,
    output logic              front_bank,
    output logic              swap_pending,
    output logic              overflow
);

    // Pixel count widened so the range check also works for a 64K bank
    localparam logic [16:0] C_NUM_PIXELS = 17'(NUM_PIXELS);

    state_t            state_q;
    logic [7:0]        addr_hi_q;
    logic [7:0]        pix_hi_q;
    logic [ADDR_W-1:0] index_q;
    logic              wr_en_q;
    logic [ADDR_W:0]   wr_addr_q;
    logic [15:0]       wr_data_q;
    logic              overflow_q;

    state_t            w_state;
    logic [15:0]       w_start_idx;
    logic              w_start_oor;
    logic              w_swap_req;
    logic              w_front_bank;

    // A byte arriving with rx_first is decoded as the command byte
    assign w_state     = rx_first ? CMD : state_q;
    assign w_start_idx = {addr_hi_q, rx_data};
    assign w_start_oor = ({1'b0, w_start_idx} >= C_NUM_PIXELS);
    assign w_swap_req  = rx_valid && (w_state == CMD) && (rx_data == CMD_SWAP);

    frame_bank_ctl u_bank_ctl (
        .clock        (clock),
        .reset        (reset),
        .swap_req     (w_swap_req),
        .frame_done   (frame_done),
        .front_bank   (w_front_bank),
        .swap_pending (swap_pending)
    );

    // Byte-stream parser with registered write port
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_hi_q  <= '0;
            pix_hi_q   <= '0;
            index_q    <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            if (rx_first) begin
                state_q    <= CMD;
                overflow_q <= 1'b0;
            end
            if (rx_valid) begin
                case (w_state)
                    CMD: begin
                        state_q <= (rx_data == CMD_WRITE) ? ADDR_HI : DISCARD;
                    end
                    ADDR_HI: begin
                        addr_hi_q <= rx_data;
                        state_q   <= ADDR_LO;
                    end
                    ADDR_LO: begin
                        if (w_start_oor) begin
                            overflow_q <= 1'b1;
                            state_q    <= DISCARD;
                        end else begin
                            index_q <= w_start_idx[ADDR_W-1:0];
                            state_q <= PIX_HI;
                        end
                    end
                    PIX_HI: begin
                        pix_hi_q <= rx_data;
                        state_q  <= PIX_LO;
                    end
                    PIX_LO: begin
                        // Back bank sampled now, so a coinciding swap still
                        // lands this pixel in the pre-swap back bank
                        wr_en_q   <= 1'b1;
                        wr_data_q <= {pix_hi_q, rx_data};
                        wr_addr_q <= {~w_front_bank, index_q};
                        if (&index_q) begin
                            state_q <= DISCARD;
                        end else begin
                            index_q <= index_q + 1'b1;
                            state_q <= PIX_HI;
                        end
                    end
                    DISCARD: begin
                        overflow_q <= 1'b1;
                    end
                    default: begin
                        // IDLE: bytes outside a transaction are ignored
                    end
                endcase
            end
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign overflow   = overflow_q;
    assign front_bank = w_front_bank;

endmodule : spi_frame_loader
`default_nettype wire

// File: tb/tb_spi_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_frame_loader
//  Brief    : Scenario bench for spi_frame_loader with a write scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_frame_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_first = 1'b0;
    logic        frame_done = 1'b0;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [15:0] wr_data;
    logic        front_bank;
    logic        swap_pending;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    // {wr_addr, wr_data} of expected and observed writes
    logic [27:0] exp_q[$];
    logic [27:0] obs_q[$];

    spi_frame_loader #(.NUM_PIXELS(2048)) dut (
        .clock        (clock),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_first     (rx_first),
        .frame_done   (frame_done),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .front_bank   (front_bank),
        .swap_pending (swap_pending),
        .overflow     (overflow)
    );

    always #5 clock = ~clock;

    // Record every write strobe away from the active edge
    always @(negedge clock) begin
        if (wr_en) obs_q.push_back({wr_addr, wr_data});
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clock);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_first();
        @(negedge clock);
        rx_first = 1'b1;
        @(negedge clock);
        rx_first = 1'b0;
    endtask

    task automatic pulse_frame_done();
        @(negedge clock);
        frame_done = 1'b1;
        @(negedge clock);
        frame_done = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        total++; if (wr_en !== 1'b0)          begin bad++; $display("FAIL rst_wr_en got=%b exp=0", wr_en); end
        total++; if (wr_addr !== 12'h000)     begin bad++; $display("FAIL rst_wr_addr got=%h exp=000", wr_addr); end
        total++; if (wr_data !== 16'h0000)    begin bad++; $display("FAIL rst_wr_data got=%h exp=0000", wr_data); end
        total++; if (front_bank !== 1'b0)     begin bad++; $display("FAIL rst_front got=%b exp=0", front_bank); end
        total++; if (swap_pending !== 1'b0)   begin bad++; $display("FAIL rst_pending got=%b exp=0", swap_pending); end
        total++; if (overflow !== 1'b0)       begin bad++; $display("FAIL rst_overflow got=%b exp=0", overflow); end
        @(negedge clock);
        reset = 1'b0;
        // Bytes before any rx_first must be ignored
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h12); send_byte(8'h34);
        repeat (3) @(negedge clock);
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL idle_ignore writes got=%0d exp=0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_write();
        pulse_first();
        exp_q.push_back({12'h800, 16'h7C00});
        exp_q.push_back({12'h801, 16'h03E0});
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h7C); send_byte(8'h00); send_byte(8'h03); send_byte(8'hE0);
        repeat (4) @(negedge clock);
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL write_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [27:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++; if (o !== e) begin bad++; $display("FAIL write_data got=%h exp=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        total++; if (front_bank !== 1'b0) begin bad++; $display("FAIL write_front got=%b exp=0", front_bank); end
        total++; if ({wr_addr, wr_data} !== {12'h801, 16'h03E0}) begin bad++; $display("FAIL write_hold got=%h exp=%h", {wr_addr, wr_data}, {12'h801, 16'h03E0}); end
    endtask

    task automatic test_overflow();
        pulse_first();
        exp_q.push_back({12'hFFF, 16'hAAAA});
        send_byte(8'h01); send_byte(8'h07); send_byte(8'hFF);
        send_byte(8'hAA); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hBB);
        repeat (4) @(negedge clock);
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL ovf_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [27:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++; if (o !== e) begin bad++; $display("FAIL ovf_data got=%h exp=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", overflow); end
        pulse_first();
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
        // Start index equal to NUM_PIXELS is out of range
        send_byte(8'h01); send_byte(8'h08); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22);
        repeat (3) @(negedge clock);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_start got=%b exp=1", overflow); end
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL ovf_start_writes got=%0d exp=0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_swap();
        pulse_first();
        send_byte(8'h02);
        repeat (2) @(negedge clock);
        total++; if (swap_pending !== 1'b1) begin bad++; $display("FAIL swap_pend got=%b exp=1", swap_pending); end
        total++; if (front_bank !== 1'b0)   begin bad++; $display("FAIL swap_front_pre got=%b exp=0", front_bank); end
        pulse_frame_done();
        total++; if (front_bank !== 1'b1)   begin bad++; $display("FAIL swap_front got=%b exp=1", front_bank); end
        total++; if (swap_pending !== 1'b0) begin bad++; $display("FAIL swap_pend_clr got=%b exp=0", swap_pending); end
        pulse_first();
        exp_q.push_back({12'h000, 16'h1234});
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h12); send_byte(8'h34);
        repeat (4) @(negedge clock);
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL swap_wr_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [27:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++; if (o !== e) begin bad++; $display("FAIL swap_wr_data got=%h exp=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_swap_same_cycle();
        // front_bank is 1 here
        pulse_first();
        @(negedge clock);
        rx_data = 8'h02; rx_valid = 1'b1; frame_done = 1'b1;
        @(negedge clock);
        rx_valid = 1'b0; frame_done = 1'b0;
        total++; if (front_bank !== 1'b1)   begin bad++; $display("FAIL same_front got=%b exp=1", front_bank); end
        total++; if (swap_pending !== 1'b1) begin bad++; $display("FAIL same_pend got=%b exp=1", swap_pending); end
        pulse_first();
        send_byte(8'h02);
        pulse_frame_done();
        total++; if (front_bank !== 1'b0)   begin bad++; $display("FAIL same_toggle got=%b exp=0", front_bank); end
        total++; if (swap_pending !== 1'b0) begin bad++; $display("FAIL same_pend_clr got=%b exp=0", swap_pending); end
        pulse_frame_done();
        total++; if (front_bank !== 1'b0)   begin bad++; $display("FAIL same_single got=%b exp=0", front_bank); end
    endtask

    task automatic test_swap_during_write();
        // front_bank is 0; arm a swap then land a pixel on the swap edge
        pulse_first();
        send_byte(8'h02);
        pulse_first();
        exp_q.push_back({12'h810, 16'h1122});
        exp_q.push_back({12'h011, 16'h3344});
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h10); send_byte(8'h11);
        @(negedge clock);
        rx_data = 8'h22; rx_valid = 1'b1; frame_done = 1'b1;
        @(negedge clock);
        rx_valid = 1'b0; frame_done = 1'b0;
        send_byte(8'h33); send_byte(8'h44);
        repeat (4) @(negedge clock);
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL coin_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [27:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++; if (o !== e) begin bad++; $display("FAIL coin_data got=%h exp=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        total++; if (front_bank !== 1'b1) begin bad++; $display("FAIL coin_front got=%b exp=1", front_bank); end
    endtask

    task automatic test_odd_byte();
        // front_bank is 1, back bank 0
        pulse_first();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h55);
        // New transaction whose command byte rides on rx_first
        @(negedge clock);
        rx_first = 1'b1; rx_data = 8'h01; rx_valid = 1'b1;
        @(negedge clock);
        rx_first = 1'b0; rx_valid = 1'b0;
        exp_q.push_back({12'h001, 16'hABCD});
        send_byte(8'h00); send_byte(8'h01); send_byte(8'hAB); send_byte(8'hCD);
        repeat (4) @(negedge clock);
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL odd_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [27:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++; if (o !== e) begin bad++; $display("FAIL odd_data got=%h exp=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid();
        pulse_first();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h05); send_byte(8'h12);
        @(negedge clock);
        reset = 1'b1;
        rx_data = 8'h34; rx_valid = 1'b1;
        @(negedge clock);
        rx_valid = 1'b0;
        total++; if ({wr_en, wr_addr, wr_data} !== 29'd0) begin bad++; $display("FAIL mid_rst_wr got=%h exp=0", {wr_en, wr_addr, wr_data}); end
        total++; if ({front_bank, swap_pending, overflow} !== 3'b000) begin bad++; $display("FAIL mid_rst_flags got=%b exp=000", {front_bank, swap_pending, overflow}); end
        @(negedge clock);
        reset = 1'b0;
        send_byte(8'h34); send_byte(8'h56);
        repeat (4) @(negedge clock);
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL mid_rst_writes got=%0d exp=0", obs_q.size()); end
        total++; if ({wr_addr, wr_data, overflow} !== 29'd0) begin bad++; $display("FAIL mid_rst_after got=%h exp=0", {wr_addr, wr_data, overflow}); end
        obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_write();
        test_overflow();
        test_swap();
        test_swap_same_cycle();
        test_swap_during_write();
        test_odd_byte();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_spi_frame_loader
`default_nettype wire
